instr_cycle_ctrl: RTL and testbench
===================================

Name: instr_cycle_ctrl

Overview:
- Parametrised next-generation instruction-cycle controller for the 8-bit micro: fetch, decode, data-memory access, execute sequencing.
- Adds a ready/ack handshake on data memory (wait states), CALL/RET with a hardware return stack, HALT/resume, and fault reporting.
- Sits between instruction ROM, data RAM and the ALU datapath. Drives Exec, IR, IBR and MBR to the ALU and consumes Flags and AR.

Parameters:
INST_ADDR_WIDTH, 8, PC / instruction address width
INST_DATA_WIDTH, 8, instruction byte width (opcode and immediate)
MEM_ADDR_WIDTH, 8, data memory address width
MEM_DATA_WIDTH, 8, data memory word width
STACK_DEPTH, 4, return-stack entries (>=1)

Ports:
clk  in  1  system clock, rising edge
arst_n  in  1  asynchronous active-low reset
inst_addr  out  INST_ADDR_WIDTH  = PC
inst_data  in  INST_DATA_WIDTH  combinational ROM data for inst_addr
mem_addr  out  MEM_ADDR_WIDTH  = MAR
mem_data_i  in  MEM_DATA_WIDTH  read data, valid when mem_ack=1
mem_data_o  out  MEM_DATA_WIDTH  write data
mem_req  out  1  access request, held until ack
mem_we  out  1  write qualifier, valid with mem_req
mem_ack  in  1  access complete this cycle
Exec  out  1  one-cycle execute strobe to ALU
Flags  in  4  ZERO/CARRY/NEG/OV, bit indices from defines
AR  in  MEM_DATA_WIDTH  accumulator
IR  out  INST_DATA_WIDTH  instruction register
IBR  out  INST_DATA_WIDTH  immediate buffer register
MBR  out  MEM_DATA_WIDTH  memory read buffer
resume  in  1  leave HALT state (software halt only)
halted  out  1  high in ST_HALT
fault  out  2  sticky: [0] stack overflow, [1] stack underflow

Behaviour:
- Reset (arst_n=0, asynchronous): PC, MAR, MBR_o, IR, IBR, MBR = 0; mem_req, mem_we, Exec = 0; halted = 0; fault = 0; sp = 0; state = ST_FETCH.
- Every instruction is 2 bytes (opcode, immediate).
- ST_FETCH: IR<=inst_data; PC<=PC+1; go to ST_DECODE.
- ST_DECODE: IBR<=inst_data; PC<=PC+1.
  - STORE_X: MAR<=IBR, MBR_o<=AR.
  - STORE_I: MAR<=AR, MBR_o<=IBR.
  - LOAD_X, or ALU class (IR[7:6]=01/10) with OPER2_X: MAR<=IBR.
  - Any of the above: mem_req<=1, mem_we<=1 for stores, go to ST_MEM. Else go to ST_EXECUTE.
- ST_MEM:
  - mem_req, mem_we and mem_addr stay stable while mem_ack=0 (unbounded wait).
  - On mem_ack=1: MBR<=mem_data_i if read; mem_req<=0, mem_we<=0 on the next edge; go to ST_EXECUTE.
  - Minimum access = 1 cycle.
- ST_EXECUTE: Exec=1 for exactly this cycle; next state ST_FETCH unless stated.
  - Jumps: JMP/JZ/JC/JN/JV set PC<=PC+sext(IBR) when taken. IBR is two's complement, sign-extended or truncated to INST_ADDR_WIDTH; sum wraps mod 2^INST_ADDR_WIDTH.
  - CALL: if sp<STACK_DEPTH, push PC (address after CALL), sp<=sp+1, PC<=PC+sext(IBR). If full: no push, fault[0]<=1, go to ST_HALT.
  - RET: if sp>0, PC<=stack[sp-1], sp<=sp-1. If empty: fault[1]<=1, go to ST_HALT.
  - HALT: go to ST_HALT.
  - Unknown opcode: Exec pulse only, no other effect.
- ST_HALT: halted=1, no fetch, PC frozen.
  - resume=1 with fault==0: go to ST_FETCH next cycle.
  - resume is ignored while any fault bit is set; only reset clears fault.
- Latency: 3 cycles for non-memory instructions; 4+wait cycles for memory instructions.
- Reset mid-access drops mem_req immediately (asynchronous); the memory must tolerate an aborted request.
- Stack contents are not cleared by reset; only sp is. RET after reset faults.

Decomposition:
- Shared defines package:
  - opcodes: STORE_X, STORE_I, LOAD_X, JMP, JZ, JC, JN, JV, CALL, RET, HALT
  - ALU_OPER2_BIT, OPER2_X
  - flag indices ZERO/CARRY/NEG/OV
  - state encodings ST_FETCH/ST_DECODE/ST_MEM/ST_EXECUTE/ST_HALT
- Sub-module ret_stack:
  - parametrised LIFO (WIDTH=INST_ADDR_WIDTH, DEPTH=STACK_DEPTH)
  - push/pop inputs, full/empty outputs, top output
  - push when full and pop when empty are ignored internally

Test Plan:
- Reset then NOP stream, mem_ack tied 1 -> inst_addr 0,1,2,...; Exec high every 3rd cycle; mem_req never asserted.
- STORE_X imm=0x20 with AR=0x5A, mem_ack delayed 3 cycles -> mem_addr=0x20, mem_data_o=0x5A, mem_req/mem_we held 3 cycles, then Exec, next fetch at PC=2.
- LOAD_X imm=0x10, RAM[0x10]=0xA7, 1-cycle ack -> MBR=0xA7 before the Exec cycle.
- JZ imm=0xFC at PC=0x10 with Flags[ZERO]=1 -> next fetch at 0x0E (0x12-4). With ZERO=0 -> next fetch at 0x12. JMP imm=0x05 at PC=0xFC -> PC wraps to 0x03.
- CALL imm=0x08 at PC=0 then RET at target -> PC 0x0A, then return to 0x02. STACK_DEPTH+1 nested CALLs -> fault=01, halted=1, resume ignored.
- HALT then resume pulse -> halted 1 until resume, fetch resumes at next PC. arst_n low during ST_MEM -> mem_req=0 immediately, PC=0.

Source files
------------

// File: rtl/instr_cycle_ctrl_pkg.sv
// Shared opcode, flag and state definitions for the instruction-cycle controller.
// Opcodes 0xC0..0xCF are control/memory ops; IR[7:6]=01/10 is the ALU class.
package instr_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StMem     = 3'd2,
    StExecute = 3'd3,
    StHalt    = 3'd4
  } state_e;

  localparam logic [7:0] OpStoreX = 8'hC0;
  localparam logic [7:0] OpStoreI = 8'hC1;
  localparam logic [7:0] OpLoadX  = 8'hC2;
  localparam logic [7:0] OpJmp    = 8'hC8;
  localparam logic [7:0] OpJz     = 8'hC9;
  localparam logic [7:0] OpJc     = 8'hCA;
  localparam logic [7:0] OpJn     = 8'hCB;
  localparam logic [7:0] OpJv     = 8'hCC;
  localparam logic [7:0] OpCall   = 8'hCD;
  localparam logic [7:0] OpRet    = 8'hCE;
  localparam logic [7:0] OpHalt   = 8'hCF;

  // ALU instructions take their second operand from memory when this bit equals Oper2X.
  localparam int unsigned AluOper2Bit = 5;
  localparam logic        Oper2X      = 1'b1;

  localparam int unsigned FlagZero  = 0;
  localparam int unsigned FlagCarry = 1;
  localparam int unsigned FlagNeg   = 2;
  localparam int unsigned FlagOv    = 3;

  function automatic logic is_store(input logic [7:0] op);
    return (op == OpStoreX) || (op == OpStoreI);
  endfunction

  function automatic logic needs_mem(input logic [7:0] op);
    logic alu_class;
    alu_class = (op[7:6] == 2'b01) || (op[7:6] == 2'b10);
    return is_store(op) || (op == OpLoadX) || (alu_class && (op[AluOper2Bit] == Oper2X));
  endfunction

endpackage

// File: rtl/instr_cycle_ctrl_ret_stack.sv
// Return-address LIFO. Push when full and pop when empty are silently dropped.
// Storage is not reset; only the stack pointer is.
module instr_cycle_ctrl_ret_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned SpW  = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SpW-1:0]   sp_q, sp_d;
  logic [SpW-1:0]   top_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (sp_q == SpW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_idx = sp_q - SpW'(1);
  assign top_o   = mem_q[top_idx[PtrW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[sp_q[PtrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Fetch/decode/memory/execute sequencer for the 8-bit micro, with data-memory
// wait states, CALL/RET return stack, HALT/resume and sticky stack-fault reporting.
module instr_cycle_ctrl
  import instr_cycle_ctrl_pkg::*;
#(
  parameter int unsigned INST_ADDR_WIDTH = 8,
  parameter int unsigned INST_DATA_WIDTH = 8,
  parameter int unsigned MEM_ADDR_WIDTH  = 8,
  parameter int unsigned MEM_DATA_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       arst_n,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr,
  input  logic [INST_DATA_WIDTH-1:0] inst_data,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_data_i,
  output logic [MEM_DATA_WIDTH-1:0]  mem_data_o,
  output logic                       mem_req,
  output logic                       mem_we,
  input  logic                       mem_ack,
  output logic                       Exec,
  input  logic [3:0]                 Flags,
  input  logic [MEM_DATA_WIDTH-1:0]  AR,
  output logic [INST_DATA_WIDTH-1:0] IR,
  output logic [INST_DATA_WIDTH-1:0] IBR,
  output logic [MEM_DATA_WIDTH-1:0]  MBR,
  input  logic                       resume,
  output logic                       halted,
  output logic [1:0]                 fault
);

  state_e                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [MEM_ADDR_WIDTH-1:0]  mar_q, mar_d;
  logic [MEM_DATA_WIDTH-1:0]  mbr_o_q, mbr_o_d;
  logic [INST_DATA_WIDTH-1:0] ir_q, ir_d;
  logic [INST_DATA_WIDTH-1:0] ibr_q, ibr_d;
  logic [MEM_DATA_WIDTH-1:0]  mbr_q, mbr_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [1:0]                 fault_q, fault_d;

  logic [7:0]                 op;
  logic [INST_ADDR_WIDTH-1:0] ibr_ext;
  logic [INST_ADDR_WIDTH-1:0] jmp_target;
  logic                       stk_push, stk_pop, stk_full, stk_empty;
  logic [INST_ADDR_WIDTH-1:0] stk_top;

  assign op = ir_q[7:0];

  // Branch offsets are two's complement relative to the address after the immediate.
  if (INST_ADDR_WIDTH > INST_DATA_WIDTH) begin : gen_sext
    assign ibr_ext = {{(INST_ADDR_WIDTH - INST_DATA_WIDTH){ibr_q[INST_DATA_WIDTH-1]}}, ibr_q};
  end else begin : gen_trunc
    assign ibr_ext = ibr_q[INST_ADDR_WIDTH-1:0];
  end

  assign jmp_target = pc_q + ibr_ext;

  instr_cycle_ctrl_ret_stack #(
    .WIDTH (INST_ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_i   (clk),
    .rst_ni  (arst_n),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc_q),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mar_d     = mar_q;
    mbr_o_d   = mbr_o_q;
    ir_d      = ir_q;
    ibr_d     = ibr_q;
    mbr_d     = mbr_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    fault_d   = fault_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;

    unique case (state_q)
      StFetch: begin
        ir_d    = inst_data;
        pc_d    = pc_q + INST_ADDR_WIDTH'(1);
        state_d = StDecode;
      end
      StDecode: begin
        // The immediate is still on inst_data this cycle; IBR only captures it at the edge.
        ibr_d   = inst_data;
        pc_d    = pc_q + INST_ADDR_WIDTH'(1);
        state_d = StExecute;
        if (needs_mem(op)) begin
          mem_req_d = 1'b1;
          mem_we_d  = is_store(op);
          state_d   = StMem;
          if (op == OpStoreX) begin
            mar_d   = MEM_ADDR_WIDTH'(inst_data);
            mbr_o_d = AR;
          end else if (op == OpStoreI) begin
            mar_d   = MEM_ADDR_WIDTH'(AR);
            mbr_o_d = MEM_DATA_WIDTH'(inst_data);
          end else begin
            mar_d   = MEM_ADDR_WIDTH'(inst_data);
          end
        end
      end
      StMem: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            mbr_d = mem_data_i;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StExecute;
        end
      end
      StExecute: begin
        state_d = StFetch;
        unique case (op)
          OpJmp: pc_d = jmp_target;
          OpJz:  if (Flags[FlagZero])  pc_d = jmp_target;
          OpJc:  if (Flags[FlagCarry]) pc_d = jmp_target;
          OpJn:  if (Flags[FlagNeg])   pc_d = jmp_target;
          OpJv:  if (Flags[FlagOv])    pc_d = jmp_target;
          OpCall: begin
            if (!stk_full) begin
              stk_push = 1'b1;
              pc_d     = jmp_target;
            end else begin
              fault_d[0] = 1'b1;
              state_d    = StHalt;
            end
          end
          OpRet: begin
            if (!stk_empty) begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
            end else begin
              fault_d[1] = 1'b1;
              state_d    = StHalt;
            end
          end
          OpHalt:  state_d = StHalt;
          default: ;
        endcase
      end
      StHalt: begin
        if (resume && (fault_q == 2'b00)) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      mar_q     <= '0;
      mbr_o_q   <= '0;
      ir_q      <= '0;
      ibr_q     <= '0;
      mbr_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      fault_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      mbr_o_q   <= mbr_o_d;
      ir_q      <= ir_d;
      ibr_q     <= ibr_d;
      mbr_q     <= mbr_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      fault_q   <= fault_d;
    end
  end

  assign inst_addr  = pc_q;
  assign mem_addr   = mar_q;
  assign mem_data_o = mbr_o_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign IR         = ir_q;
  assign IBR        = ibr_q;
  assign MBR        = mbr_q;
  assign fault      = fault_q;
  assign Exec       = (state_q == StExecute);
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Scoreboard bench for instr_cycle_ctrl: directed programs push expected execute
// records and memory accesses; two monitors pop and compare as the DUT presents them.
module tb_instr_cycle_ctrl;

  logic       clk;
  logic       arst_n;
  logic [7:0] inst_addr, inst_data;
  logic [7:0] mem_addr, mem_data_i, mem_data_o;
  logic       mem_req, mem_we, mem_ack;
  logic       Exec;
  logic [3:0] Flags;
  logic [7:0] AR, IR, IBR, MBR;
  logic       resume, halted;
  logic [1:0] fault;

  logic [7:0] rom [256];
  logic [7:0] ram [256];
  int         ack_delay;
  int         wait_cnt;
  int         cyc;
  int         total;
  int         bad;

  typedef struct {
    logic [7:0] ir;
    logic [7:0] ibr;
    logic [7:0] mbr;
    bit         chk_mbr;
    logic [7:0] next_pc;
    logic       halted;
    int         gap;
  } exec_t;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    int         cycles;
  } mem_t;

  exec_t exec_q[$];
  mem_t  mem_q[$];

  instr_cycle_ctrl dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .mem_addr   (mem_addr),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .Exec       (Exec),
    .Flags      (Flags),
    .AR         (AR),
    .IR         (IR),
    .IBR        (IBR),
    .MBR        (MBR),
    .resume     (resume),
    .halted     (halted),
    .fault      (fault)
  );

  assign inst_data = rom[inst_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_exec(input logic [7:0] ir, input logic [7:0] ibr, input logic [7:0] mbr,
                           input bit chk_mbr, input logic [7:0] next_pc, input logic h,
                           input int gap);
    exec_t e;
    e.ir = ir; e.ibr = ibr; e.mbr = mbr; e.chk_mbr = chk_mbr;
    e.next_pc = next_pc; e.halted = h; e.gap = gap;
    exec_q.push_back(e);
  endtask

  task automatic push_mem(input logic [7:0] addr, input logic we, input logic [7:0] wdata,
                          input int cycles);
    mem_t m;
    m.addr = addr; m.we = we; m.wdata = wdata; m.cycles = cycles;
    mem_q.push_back(m);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h00;
      ram[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exec_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_drain"}, exec_q.size() + mem_q.size(), 0);
    exec_q.delete();
    mem_q.delete();
  endtask

  // Data memory responder: acks after ack_delay idle cycles of an outstanding request.
  always @(posedge clk) begin
    #1;
    if (mem_req === 1'b1) begin
      if (wait_cnt == ack_delay) begin
        mem_ack    = 1'b1;
        mem_data_i = ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_data_o;
        wait_cnt   = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Execute monitor: captures registers in the Exec cycle and the PC one cycle later.
  initial begin
    int         last_cyc;
    int         this_cyc;
    logic [7:0] g_ir, g_ibr, g_mbr;
    exec_t      e;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (arst_n === 1'b1 && Exec === 1'b1) begin
        g_ir = IR; g_ibr = IBR; g_mbr = MBR; this_cyc = cyc;
        @(negedge clk);
        if (exec_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL exec_unexpected got ir=%0h expected no execute", g_ir);
        end else begin
          e = exec_q.pop_front();
          chk("exec_ir", g_ir, e.ir);
          chk("exec_ibr", g_ibr, e.ibr);
          if (e.chk_mbr) chk("exec_mbr", g_mbr, e.mbr);
          chk("exec_next_pc", inst_addr, e.next_pc);
          chk("exec_halted", halted, e.halted);
          if (e.gap != 0) chk("exec_gap", this_cyc - last_cyc, e.gap);
        end
        last_cyc = this_cyc;
      end
    end
  end

  // Memory monitor: checks address/qualifier stability and wait length on each ack.
  initial begin
    int         req_cyc;
    bit         unstable;
    logic [7:0] first_addr;
    logic       first_we;
    mem_t       m;
    req_cyc = 0;
    unstable = 0;
    forever begin
      @(negedge clk);
      if (arst_n === 1'b1 && mem_req === 1'b1) begin
        if (req_cyc == 0) begin
          first_addr = mem_addr;
          first_we   = mem_we;
        end
        req_cyc++;
        if (mem_addr !== first_addr || mem_we !== first_we) unstable = 1;
        if (mem_ack === 1'b1) begin
          if (mem_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mem_unexpected got addr=%0h expected no access", mem_addr);
          end else begin
            m = mem_q.pop_front();
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_we", mem_we, m.we);
            if (m.we) chk("mem_wdata", mem_data_o, m.wdata);
            chk("mem_req_cycles", req_cyc, m.cycles);
            chk("mem_stable", unstable, 0);
          end
          req_cyc  = 0;
          unstable = 0;
        end
      end else begin
        req_cyc  = 0;
        unstable = 0;
      end
    end
  end

  initial begin
    int n;
    total = 0; bad = 0;
    arst_n = 1'b0; resume = 1'b0; Flags = 4'h0; AR = 8'h00;
    mem_ack = 1'b0; mem_data_i = 8'h00; ack_delay = 0; wait_cnt = 0;
    clear_mem();

    // NOP stream ending in HALT, then resume into a second HALT
    rom[8'h08] = 8'hCF;
    rom[8'h0C] = 8'hCF;
    push_exec(8'h00, 8'h00, 8'h00, 1, 8'h02, 1'b0, 0);
    push_exec(8'h00, 8'h00, 8'h00, 1, 8'h04, 1'b0, 3);
    push_exec(8'h00, 8'h00, 8'h00, 1, 8'h06, 1'b0, 3);
    push_exec(8'h00, 8'h00, 8'h00, 1, 8'h08, 1'b0, 3);
    push_exec(8'hCF, 8'h00, 8'h00, 1, 8'h0A, 1'b1, 3);
    repeat (2) @(negedge clk);
    chk("rst_pc", inst_addr, 8'h00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_exec", Exec, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 2'b00);
    chk("rst_regs", {IR, IBR, MBR, mem_addr}, 32'h0);
    chk("rst_mbr_o", mem_data_o, 8'h00);
    arst_n = 1'b1;
    wait_done("nop", 60);
    repeat (4) @(negedge clk);
    chk("halt_pc_frozen", inst_addr, 8'h0A);
    chk("halt_flag", halted, 1'b1);
    push_exec(8'h00, 8'h00, 8'h00, 0, 8'h0C, 1'b0, 0);
    push_exec(8'hCF, 8'h00, 8'h00, 0, 8'h0E, 1'b1, 3);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    wait_done("resume", 30);

    // STORE_X with a three-cycle access
    clear_mem();
    rom[2] = 8'hC0; rom[3] = 8'h20; rom[4] = 8'hCF;
    AR = 8'h5A; ack_delay = 2;
    push_exec(8'h00, 8'h00, 8'h00, 0, 8'h02, 1'b0, 0);
    push_exec(8'hC0, 8'h20, 8'h00, 0, 8'h04, 1'b0, 6);
    push_exec(8'hCF, 8'h00, 8'h00, 0, 8'h06, 1'b1, 3);
    push_mem(8'h20, 1'b1, 8'h5A, 3);
    do_reset();
    wait_done("store_x", 60);
    chk("ram_store_x", ram[8'h20], 8'h5A);

    // LOAD_X, ALU memory operand, ALU register operand, STORE_I
    clear_mem();
    rom[2] = 8'hC2; rom[3] = 8'h10;
    rom[4] = 8'h60; rom[5] = 8'h11;
    rom[6] = 8'h40;
    rom[8] = 8'hC1; rom[9] = 8'h99;
    rom[10] = 8'hCF;
    ram[8'h10] = 8'hA7; ram[8'h11] = 8'h3C;
    AR = 8'h30; ack_delay = 0;
    push_exec(8'h00, 8'h00, 8'h00, 1, 8'h02, 1'b0, 0);
    push_exec(8'hC2, 8'h10, 8'hA7, 1, 8'h04, 1'b0, 4);
    push_exec(8'h60, 8'h11, 8'h3C, 1, 8'h06, 1'b0, 4);
    push_exec(8'h40, 8'h00, 8'h3C, 1, 8'h08, 1'b0, 3);
    push_exec(8'hC1, 8'h99, 8'h3C, 1, 8'h0A, 1'b0, 4);
    push_exec(8'hCF, 8'h00, 8'h3C, 1, 8'h0C, 1'b1, 3);
    push_mem(8'h10, 1'b0, 8'h00, 1);
    push_mem(8'h11, 1'b0, 8'h00, 1);
    push_mem(8'h30, 1'b1, 8'h99, 1);
    do_reset();
    wait_done("load", 80);
    chk("ram_store_i", ram[8'h30], 8'h99);

    // JMP then JZ taken backwards (ZERO=1), then not taken (ZERO=0)
    clear_mem();
    rom[0] = 8'hC8; rom[1] = 8'h0E;
    rom[8'h0E] = 8'hCF;
    rom[8'h10] = 8'hC9; rom[8'h11] = 8'hFC;
    rom[8'h12] = 8'hCF;
    Flags = 4'b0001;
    push_exec(8'hC8, 8'h0E, 8'h00, 0, 8'h10, 1'b0, 0);
    push_exec(8'hC9, 8'hFC, 8'h00, 0, 8'h0E, 1'b0, 3);
    push_exec(8'hCF, 8'h00, 8'h00, 0, 8'h10, 1'b1, 3);
    do_reset();
    wait_done("jz_taken", 40);
    Flags = 4'b1110;
    push_exec(8'hC8, 8'h0E, 8'h00, 0, 8'h10, 1'b0, 0);
    push_exec(8'hC9, 8'hFC, 8'h00, 0, 8'h12, 1'b0, 3);
    push_exec(8'hCF, 8'h00, 8'h00, 0, 8'h14, 1'b1, 3);
    do_reset();
    wait_done("jz_not_taken", 40);

    // PC wrap-around on a forward jump near the top of ROM
    clear_mem();
    rom[0] = 8'hC8; rom[1] = 8'hFA;
    rom[8'hFC] = 8'hC8; rom[8'hFD] = 8'h05;
    rom[3] = 8'hCF;
    Flags = 4'h0;
    push_exec(8'hC8, 8'hFA, 8'h00, 0, 8'hFC, 1'b0, 0);
    push_exec(8'hC8, 8'h05, 8'h00, 0, 8'h03, 1'b0, 3);
    push_exec(8'hCF, 8'h00, 8'h00, 0, 8'h05, 1'b1, 3);
    do_reset();
    wait_done("jmp_wrap", 40);

    // CALL then RET
    clear_mem();
    rom[0] = 8'hCD; rom[1] = 8'h08;
    rom[8'h0A] = 8'hCE;
    rom[2] = 8'hCF;
    push_exec(8'hCD, 8'h08, 8'h00, 0, 8'h0A, 1'b0, 0);
    push_exec(8'hCE, 8'h00, 8'h00, 0, 8'h02, 1'b0, 3);
    push_exec(8'hCF, 8'h00, 8'h00, 0, 8'h04, 1'b1, 3);
    do_reset();
    wait_done("call_ret", 40);

    // Five nested CALLs overflow a four-entry stack
    clear_mem();
    for (int i = 0; i < 5; i++) rom[2*i] = 8'hCD;
    push_exec(8'hCD, 8'h00, 8'h00, 0, 8'h02, 1'b0, 0);
    push_exec(8'hCD, 8'h00, 8'h00, 0, 8'h04, 1'b0, 3);
    push_exec(8'hCD, 8'h00, 8'h00, 0, 8'h06, 1'b0, 3);
    push_exec(8'hCD, 8'h00, 8'h00, 0, 8'h08, 1'b0, 3);
    push_exec(8'hCD, 8'h00, 8'h00, 0, 8'h0A, 1'b1, 3);
    do_reset();
    wait_done("overflow", 60);
    chk("overflow_fault", fault, 2'b01);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    repeat (5) @(negedge clk);
    chk("overflow_resume_ignored", halted, 1'b1);
    chk("overflow_pc_frozen", inst_addr, 8'h0A);

    // RET straight after reset underflows; reset must clear the earlier fault
    clear_mem();
    rom[0] = 8'hCE;
    push_exec(8'hCE, 8'h00, 8'h00, 0, 8'h02, 1'b1, 0);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("fault_cleared_by_reset", fault, 2'b00);
    chk("halted_cleared_by_reset", halted, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    wait_done("underflow", 30);
    chk("underflow_fault", fault, 2'b10);

    // Reset during a stalled access drops the request asynchronously
    clear_mem();
    rom[0] = 8'hC2; rom[1] = 8'h10;
    ack_delay = 50;
    do_reset();
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_req_seen", mem_req, 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_pc", inst_addr, 8'h00);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_queues", exec_q.size() + mem_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
